// File: rtl/fd_spi_master.sv
// fd_spi_master -- single-frame SPI master, mode 0, 24-bit frames, three chip selects.
//
// A transfer request (start_i) taken while idle latches data_i/cs_sel_i, drops the
// selected chip select, shifts 24 bits MSB first and returns a one-cycle done_o.
// Every SPI pin is driven straight from a flop.
//
// Parameters
//   g_clk_div : system clocks per SCLK half-period (2..255). This also sets the
//               CS setup and CS hold times.
//
// Optional feature
//   FD_SPI_READBACK_EN : when defined, MISO is shifted in on each SCLK rising edge and
//                        rdata_o is loaded with the full frame in the done_o cycle.
//                        When undefined, there is no capture register, rdata_o is
//                        tied to 0 and spi_miso_i is ignored.
//
// Ports
//   clk_sys_i       in   system clock, rising edge
//   rst_n_sys_i     in   asynchronous active-low reset
//   start_i         in   single-cycle transfer request
//   cs_sel_i[1:0]   in   target: 0=DAC 1=PLL 2=GPIO 3=reserved (request ignored)
//   data_i[23:0]    in   frame to transmit
//   busy_o          out  transfer in progress
//   done_o          out  one-cycle completion strobe
//   rdata_o[23:0]   out  frame captured from MISO
//   spi_cs_*_n_o    out  active-low chip selects
//   spi_sclk_o      out  serial clock, idles low
//   spi_mosi_o      out  serial data out
//   spi_miso_i      in   serial data in

module fd_spi_master #(
    parameter int g_clk_div = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_sys_i,
    input  logic        start_i,
    input  logic [1:0]  cs_sel_i,
    input  logic [23:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [23:0] rdata_o,
    output logic        spi_cs_dac_n_o,
    output logic        spi_cs_pll_n_o,
    output logic        spi_cs_gpio_n_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_HIGH,
        SHIFT_LOW,
        CS_HOLD
    } state_t;

    // The phase counter is loaded with div-1 and counts down, so each state lasts
    // exactly g_clk_div cycles.
    localparam logic [7:0] DIV_LD   = 8'(g_clk_div - 1);
    localparam logic [4:0] LAST_BIT = 5'd23;

    state_t      state;
    logic [7:0]  cnt;
    logic [4:0]  bit_cnt;
    logic [23:0] tx_sr;

`ifdef FD_SPI_READBACK_EN
    logic [23:0] rx_sr;
`else
    logic unused_miso;
    assign unused_miso = spi_miso_i;
    assign rdata_o     = 24'h0;
`endif

    always_ff @(posedge clk_sys_i or negedge rst_n_sys_i) begin
        if (!rst_n_sys_i) begin
            state           <= IDLE;
            cnt             <= 8'h0;
            bit_cnt         <= 5'h0;
            tx_sr           <= 24'h0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            spi_cs_dac_n_o  <= 1'b1;
            spi_cs_pll_n_o  <= 1'b1;
            spi_cs_gpio_n_o <= 1'b1;
            spi_sclk_o      <= 1'b0;
            spi_mosi_o      <= 1'b0;
`ifdef FD_SPI_READBACK_EN
            rx_sr           <= 24'h0;
            rdata_o         <= 24'h0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // IDLE is also the done_o cycle, so a request arriving together
                    // with done_o starts the next frame right away.
                    if (start_i && cs_sel_i != 2'd3) begin
                        state           <= CS_SETUP;
                        cnt             <= DIV_LD;
                        bit_cnt         <= 5'h0;
                        tx_sr           <= data_i;
                        busy_o          <= 1'b1;
                        spi_cs_dac_n_o  <= (cs_sel_i != 2'd0);
                        spi_cs_pll_n_o  <= (cs_sel_i != 2'd1);
                        spi_cs_gpio_n_o <= (cs_sel_i != 2'd2);
                        spi_mosi_o      <= data_i[23];
                    end
                end

                CS_SETUP: begin
                    if (cnt == 8'h0) begin
                        state      <= SHIFT_HIGH;
                        cnt        <= DIV_LD;
                        spi_sclk_o <= 1'b1;
`ifdef FD_SPI_READBACK_EN
                        rx_sr      <= {rx_sr[22:0], spi_miso_i};
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                SHIFT_HIGH: begin
                    if (cnt == 8'h0) begin
                        state      <= SHIFT_LOW;
                        cnt        <= DIV_LD;
                        spi_sclk_o <= 1'b0;
                        // Next bit goes out on the falling edge; after the last bit
                        // MOSI is simply left alone until CS rises.
                        if (bit_cnt != LAST_BIT) begin
                            tx_sr      <= {tx_sr[22:0], 1'b0};
                            spi_mosi_o <= tx_sr[22];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                SHIFT_LOW: begin
                    if (cnt == 8'h0) begin
                        cnt <= DIV_LD;
                        if (bit_cnt == LAST_BIT) begin
                            state <= CS_HOLD;
                        end else begin
                            state      <= SHIFT_HIGH;
                            bit_cnt    <= bit_cnt + 5'd1;
                            spi_sclk_o <= 1'b1;
`ifdef FD_SPI_READBACK_EN
                            rx_sr      <= {rx_sr[22:0], spi_miso_i};
`endif
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                CS_HOLD: begin
                    if (cnt == 8'h0) begin
                        state           <= IDLE;
                        busy_o          <= 1'b0;
                        done_o          <= 1'b1;
                        spi_cs_dac_n_o  <= 1'b1;
                        spi_cs_pll_n_o  <= 1'b1;
                        spi_cs_gpio_n_o <= 1'b1;
                        spi_mosi_o      <= 1'b0;
`ifdef FD_SPI_READBACK_EN
                        rdata_o         <= rx_sr;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fd_spi_master.sv
// Directed bench for fd_spi_master: a default-divider instance with a slave model
// that counts SCLK edges, shifts MOSI and serves MISO, plus a g_clk_div=2 instance
// used for the fast-clock timing vectors.

module tb_fd_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

`ifdef FD_SPI_READBACK_EN
    localparam logic [23:0] RB_EXP = 24'hC3F00F;
`else
    localparam logic [23:0] RB_EXP = 24'h000000;
`endif

    // default divider instance
    logic        start = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [23:0] data = 24'h0;
    logic        busy, done, cs_dac, cs_pll, cs_gpio, sclk, mosi, miso;
    logic [23:0] rdata;

    // divider 2 instance
    logic        start2 = 1'b0;
    logic [1:0]  sel2 = 2'd0;
    logic [23:0] data2 = 24'h0;
    logic        miso2 = 1'b0;
    logic        busy2, done2, cs2_dac, cs2_pll, cs2_gpio, sclk2, mosi2;
    logic [23:0] rdata2;

    fd_spi_master dut (
        .clk_sys_i(clk), .rst_n_sys_i(rst_n), .start_i(start), .cs_sel_i(sel),
        .data_i(data), .busy_o(busy), .done_o(done), .rdata_o(rdata),
        .spi_cs_dac_n_o(cs_dac), .spi_cs_pll_n_o(cs_pll), .spi_cs_gpio_n_o(cs_gpio),
        .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso)
    );

    fd_spi_master #(.g_clk_div(2)) dut2 (
        .clk_sys_i(clk), .rst_n_sys_i(rst_n), .start_i(start2), .cs_sel_i(sel2),
        .data_i(data2), .busy_o(busy2), .done_o(done2), .rdata_o(rdata2),
        .spi_cs_dac_n_o(cs2_dac), .spi_cs_pll_n_o(cs2_pll), .spi_cs_gpio_n_o(cs2_gpio),
        .spi_sclk_o(sclk2), .spi_mosi_o(mosi2), .spi_miso_i(miso2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model, instance 1 (sampled on negedge) ----------------
    logic [2:0]  csv;
    assign csv = {cs_gpio, cs_pll, cs_dac};

    logic [2:0]  p_cs = 3'b111;
    logic        p_sclk = 1'b0, p_mosi = 1'b0;
    int          edges = 0, lowcnt = 0, frames = 0, dones = 0;
    int          viol = 0, overlap = 0, stray = 0, gap = 0, rise_cyc = 0;
    logic [2:0]  mask = 3'b0;
    logic [23:0] rx = 24'h0, msr = 24'h0, pat = 24'h0;
    int          last_edges = 0, last_low = 0;
    logic [23:0] last_rx = 24'h0;
    logic [2:0]  last_mask = 3'b0;

    assign miso = msr[23];

    always @(negedge clk) begin
        p_cs   <= csv;
        p_sclk <= sclk;
        p_mosi <= mosi;
        if (done) dones <= dones + 1;
        if (done && busy) overlap <= overlap + 1;
        if (csv == 3'b111 && sclk) stray <= stray + 1;
        if (csv != 3'b111) begin
            if (p_cs == 3'b111) begin
                lowcnt <= 1;
                mask   <= ~csv;
                edges  <= 0;
                rx     <= 24'h0;
                msr    <= pat;
                frames <= frames + 1;
                gap    <= cyc - rise_cyc;
            end else begin
                lowcnt <= lowcnt + 1;
                mask   <= mask | ~csv;
                if (sclk && !p_sclk) begin
                    edges <= edges + 1;
                    rx    <= {rx[22:0], mosi};
                    msr   <= {msr[22:0], 1'b0};
                end
                if (mosi !== p_mosi && !(p_sclk && !sclk)) viol <= viol + 1;
            end
        end else if (p_cs != 3'b111) begin
            last_edges <= edges;
            last_rx    <= rx;
            last_mask  <= mask;
            last_low   <= lowcnt;
            rise_cyc   <= cyc;
        end
    end

    // ---------------- slave model, instance 2 ----------------
    logic        p2_low = 1'b0, p2_sclk = 1'b0;
    int          edges2 = 0, low2 = 0, prise2 = 0, minp = 0, maxp = 0;
    logic [23:0] rx2 = 24'h0;
    logic        low2_now;
    assign low2_now = !(cs2_dac && cs2_pll && cs2_gpio);

    always @(negedge clk) begin
        p2_low  <= low2_now;
        p2_sclk <= sclk2;
        if (low2_now) begin
            if (!p2_low) begin
                low2   <= 1;
                edges2 <= 0;
                rx2    <= 24'h0;
                minp   <= 9999;
                maxp   <= 0;
            end else begin
                low2 <= low2 + 1;
                if (sclk2 && !p2_sclk) begin
                    edges2 <= edges2 + 1;
                    rx2    <= {rx2[22:0], mosi2};
                    prise2 <= cyc;
                    if (edges2 > 0) begin
                        if (cyc - prise2 < minp) minp <= cyc - prise2;
                        if (cyc - prise2 > maxp) maxp <= cyc - prise2;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Request presented in the current cycle; n is the accept cycle.
    task automatic go(input logic [1:0] s, input logic [23:0] d, output int n);
        start = 1'b1;
        sel   = s;
        data  = d;
        n     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    int n, at, n2, at2, d0, f0;
    logic hit;

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_pins", {29'h0, csv}, 32'h7);
        chk("rst_ctl", {28'h0, sclk, mosi, busy, done}, 32'h0);
        chk("rst_rdata", {8'h0, rdata}, 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // GPIO write
        go(2'd2, 24'h0000A5, n);
        chk("gpio_busy", {31'h0, busy}, 32'h1);
        wait_done(400, at);
        chk("gpio_done_cyc", at, n + 201);
        chk("gpio_busy_at_done", {31'h0, busy}, 32'h0);
        chk("gpio_edges", last_edges, 24);
        chk("gpio_data", {8'h0, last_rx}, 32'h0000A5);
        chk("gpio_mask", {29'h0, last_mask}, 32'h4);
        chk("gpio_cs_low", last_low, 200);
        tick();
        chk("gpio_done_pulse", {31'h0, done}, 32'h0);

        // Readback on DAC
        pat = 24'hC3F00F;
        go(2'd0, 24'h5A5A5A, n);
        wait_done(400, at);
        chk("rb_done_cyc", at, n + 201);
        chk("rb_rdata", {8'h0, rdata}, {8'h0, RB_EXP});
        chk("rb_mosi", {8'h0, last_rx}, 32'h5A5A5A);
        chk("rb_mask", {29'h0, last_mask}, 32'h1);
        pat = 24'h0;

        // Reserved target is ignored
        d0 = dones;
        f0 = frames;
        go(2'd3, 24'hFFFFFF, n);
        repeat (300) tick();
        chk("rsv_done", dones - d0, 0);
        chk("rsv_frames", frames - f0, 0);
        chk("rsv_busy", {31'h0, busy}, 32'h0);
        chk("rsv_rdata_hold", {8'h0, rdata}, {8'h0, RB_EXP});

        // Start pulsed mid-frame is ignored
        d0 = dones;
        f0 = frames;
        go(2'd1, 24'h0F0F0F, n);
        repeat (49) tick();
        start = 1'b1;
        sel   = 2'd0;
        data  = 24'hFFFFFF;
        tick();
        start = 1'b0;
        wait_done(400, at);
        chk("busy_done_cyc", at, n + 201);
        chk("busy_edges", last_edges, 24);
        chk("busy_data", {8'h0, last_rx}, 32'h0F0F0F);
        chk("busy_mask", {29'h0, last_mask}, 32'h2);
        repeat (250) tick();
        chk("busy_one_done", dones - d0, 1);
        chk("busy_one_frame", frames - f0, 1);

        // Back-to-back: next request in the done cycle
        go(2'd0, 24'hABCDEF, n);
        wait_done(400, at);
        chk("b2b_first_data", {8'h0, last_rx}, 32'hABCDEF);
        start = 1'b1;
        sel   = 2'd1;
        data  = 24'h123456;
        n2    = cyc;
        tick();
        start = 1'b0;
        chk("b2b_gap", gap, 1);
        wait_done(400, at2);
        chk("b2b_done_cyc", at2, n2 + 201);
        chk("b2b_edges", last_edges, 24);
        chk("b2b_data", {8'h0, last_rx}, 32'h123456);
        chk("b2b_mask", {29'h0, last_mask}, 32'h2);

        // Reset mid-frame
        d0 = dones;
        go(2'd2, 24'hFFFFFF, n);
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (edges >= 10) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_mid_reached", {31'h0, hit}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs", {29'h0, csv}, 32'h7);
        chk("rst_mid_sclk_busy", {30'h0, sclk, busy}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_mid_no_done", dones - d0, 0);
        chk("rst_mid_rdata", {8'h0, rdata}, 32'h0);
        go(2'd2, 24'h3C3C3C, n);
        wait_done(400, at);
        chk("rst_next_done_cyc", at, n + 201);
        chk("rst_next_edges", last_edges, 24);
        chk("rst_next_data", {8'h0, last_rx}, 32'h3C3C3C);

        // Divider 2
        start2 = 1'b1;
        sel2   = 2'd1;
        data2  = 24'h800001;
        n      = cyc;
        tick();
        start2 = 1'b0;
        at = -1;
        for (int i = 0; i < 300; i++) begin
            if (done2) begin
                at = cyc;
                break;
            end
            tick();
        end
        chk("div2_done_cyc", at, n + 101);
        chk("div2_edges", edges2, 24);
        chk("div2_cs_low", low2, 100);
        chk("div2_min_period", minp, 4);
        chk("div2_max_period", maxp, 4);
        chk("div2_data", {8'h0, rx2}, 32'h800001);

        // Whole-run invariants
        chk("mosi_stable", viol, 0);
        chk("busy_done_overlap", overlap, 0);
        chk("sclk_outside_cs", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fd_spi_master.md
FD_SPI_MASTER -- requirements
Module: fd_spi_master

Interface
REQ-001 SHALL have parameter g_clk_div, default 4, meaning system clocks per SCLK half-period (legal range 2..255).
REQ-002 SHALL have port clk_sys_i  in  1  system clock; the block uses one clock, and all logic runs on its rising edge.
REQ-003 SHALL have port rst_n_sys_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  in  1  single-cycle transfer request.
REQ-005 SHALL have port cs_sel_i  in  2  target select: 0=DAC, 1=PLL, 2=GPIO, 3=reserved.
REQ-006 SHALL have port data_i  in  24  frame to transmit, MSB first.
REQ-007 SHALL have port busy_o  out  1  transfer in progress.
REQ-008 SHALL have port done_o  out  1  one-cycle completion strobe.
REQ-009 SHALL have port rdata_o  out  24  frame captured from MISO.
REQ-010 SHALL have port spi_cs_dac_n_o, spi_cs_pll_n_o, spi_cs_gpio_n_o  out  1 each  chip selects, active-low.
REQ-011 SHALL have port spi_sclk_o  out  1  serial clock, mode 0 (idle low).
REQ-012 SHALL have port spi_mosi_o  out  1  serial data out.
REQ-013 SHALL have port spi_miso_i  in  1  serial data in.

Function
REQ-014 SHALL drive all SPI outputs from registers (no combinational paths to pins).
REQ-015 SHALL implement states IDLE, CS_SETUP, SHIFT_HIGH, SHIFT_LOW, CS_HOLD.
REQ-016 SHALL accept start_i only in IDLE with cs_sel_i in 0..2; data_i and cs_sel_i are latched in the accept cycle N.
REQ-017 SHALL ignore start_i while busy, and SHALL ignore start_i with cs_sel_i=3 (no CS assertion, no done_o).
REQ-018 SHALL, at cycle N+1, assert only the selected CS, drive spi_mosi_o=data bit 23, and enter CS_SETUP.
REQ-019 SHALL stay g_clk_div cycles in each of CS_SETUP, SHIFT_HIGH, SHIFT_LOW and CS_HOLD, with SCLK low except in SHIFT_HIGH.
REQ-020 SHALL produce exactly 24 SCLK rising edges per frame, with MOSI changing only on SCLK falling edges and MOSI held stable across each rising edge.
REQ-021 SHALL, after the 24th SHIFT_LOW, enter CS_HOLD; after CS_HOLD, deassert CS, pulse done_o for one cycle, and return to IDLE.
REQ-022 SHALL hold CS low for exactly 50*g_clk_div cycles and pulse done_o at cycle N+1+50*g_clk_div (N+201 for the default).
REQ-023 SHALL assert busy_o from N+1 until the cycle before done_o; busy_o and done_o are never high together.
REQ-024 SHALL sample spi_miso_i on each SCLK rising-edge cycle into a 24-bit shift register, MSB first.
REQ-025 SHALL update rdata_o in the done_o cycle and hold it until the next completed transfer.
REQ-026 SHALL accept a start_i presented in the done_o cycle, so back-to-back frames are separated by at least one cycle of all CS high.
REQ-027 SHALL drive spi_mosi_o low while in IDLE.

Reset
REQ-028 SHALL, on rst_n_sys_i low, immediately force all CS high, spi_sclk_o=0, spi_mosi_o=0, busy_o=0, done_o=0, rdata_o=0, and state IDLE.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame with no done_o and no rdata_o update; the first start after release behaves per REQ-016.

Configuration
REQ-030 SHALL, with macro FD_SPI_READBACK_EN defined, implement MISO capture per REQ-024/REQ-025.
REQ-031 SHALL, without FD_SPI_READBACK_EN, omit the capture register, tie rdata_o to 0, and ignore spi_miso_i; all other timing is unchanged.

Verification
REQ-032 SHALL verify GPIO write: cs_sel=2, data=0x0000A5, default divider -> a slave counting 24 SCLK edges latches 0xA5 on CS rise; done_o at N+201.
REQ-033 SHALL verify readback (macro defined): cs_sel=0, MISO driven with 0xC3F00F MSB-first -> rdata_o=0xC3F00F in the done_o cycle; macro undefined -> rdata_o=0.
REQ-034 SHALL verify request rejection: start with cs_sel=3 -> no CS low, no SCLK edges, no done_o; start pulsed at N+50 during a busy frame -> ignored, exactly 24 edges.
REQ-035 SHALL verify back-to-back frames: start in the done_o cycle with cs_sel=1, data=0x123456 -> PLL CS falls one cycle after the DAC CS rises, exactly 24 edges, MOSI=0x123456.
REQ-036 SHALL verify reset mid-frame: reset asserted after 10 SCLK edges -> CS high and SCLK low within the same timestep, no done_o, and the next frame is correct.
REQ-037 SHALL verify g_clk_div=2: 24 edges at a 4-cycle SCLK period and CS low for 100 cycles.
